sa_cost_accumulator: RTL and testbench

- Sits directly downstream of the 9x9 Manhattan distance table in the simulated-annealing placement pipeline.
- Each beat carries four distances for one neighbour of the swap pair (A, B): current-placement da/db and post-swap da/db.
- The block sums the current and post-swap distances over all beats of one swap candidate, computes the signed cost delta, and issues an accept/reject decision over a valid/ready handshake to the swap-commit stage.

---
 rtl/sa_cost_accumulator_pkg.sv | 24 ++
 rtl/sa_cost_accumulator_delta_cmp.sv | 24 ++
 rtl/sa_cost_accumulator.sv | 130 +++++++++++++
 tb/tb_sa_cost_accumulator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_cost_accumulator_pkg.sv
// Shared constants and state encoding for the SA cost accumulator slice.
// Optional threshold accept rule is enabled by SA_COST_THRESH_EN.
package sa_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned DIST_W    = 10;
  localparam int unsigned MAX_NEIGH = 4;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned SUM_W     = DIST_W + clog2(2 * MAX_NEIGH);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/sa_cost_accumulator_delta_cmp.sv
// Combinational cost delta and accept decision, shared with swap-commit.
// SA_COST_THRESH_EN adds the thresh input and the thresholded accept rule.
module sa_delta_cmp
  import sa_pkg::*;
(
  input  logic [SUM_W-1:0] cur_sum,
  input  logic [SUM_W-1:0] new_sum,
`ifdef SA_COST_THRESH_EN
  input  logic [7:0]       thresh,
`endif
  output logic [SUM_W:0]   delta,
  output logic             accept
);

  assign delta = {1'b0, new_sum} - {1'b0, cur_sum};

`ifdef SA_COST_THRESH_EN
  assign accept = $signed(delta) <= $signed({{(SUM_W + 1 - 8){1'b0}}, thresh});
`else
  // delta <= 0 : negative (sign bit) or exactly zero
  assign accept = delta[SUM_W] || (delta == '0);
`endif

endmodule

// File: rtl/sa_cost_accumulator.sv
// Accumulates current/post-swap distances per swap candidate and holds a
// decision over valid/ready. SA_COST_THRESH_EN adds the thresh port.
module sa_cost_accumulator
  import sa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DIST_W-1:0] cur_da,
  input  logic [DIST_W-1:0] cur_db,
  input  logic [DIST_W-1:0] new_da,
  input  logic [DIST_W-1:0] new_db,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_accept,
  output logic [SUM_W:0]    out_delta,
  output logic [SUM_W-1:0]  out_cur_sum,
  output logic [SUM_W-1:0]  out_new_sum,
  output logic [CNT_W-1:0]  out_beats,
  output logic              out_trunc
`ifdef SA_COST_THRESH_EN
  ,
  input  logic [7:0]        thresh
`endif
);

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   cur_sum_q, cur_sum_d;
  logic [SUM_W-1:0]   new_sum_q, new_sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trunc_q, trunc_d;
  logic [SUM_W-1:0]   beat_cur, beat_new;
  logic               cmp_accept;
`ifdef SA_COST_THRESH_EN
  logic [7:0]         thresh_q, thresh_d;
`endif

  always_comb begin
    state_d   = state_q;
    cur_sum_d = cur_sum_q;
    new_sum_d = new_sum_q;
    cnt_d     = cnt_q;
    trunc_d   = trunc_q;
`ifdef SA_COST_THRESH_EN
    thresh_d  = thresh_q;
`endif
    beat_cur  = SUM_W'(cur_da) + SUM_W'(cur_db);
    beat_new  = SUM_W'(new_da) + SUM_W'(new_db);

    unique case (state_q)
      ACC: begin
        if (in_valid) begin
          // Sums are zero after reset/release, so a missing in_first
          // accumulates onto zero and behaves like a fresh start.
          if (in_first) begin
            cur_sum_d = beat_cur;
            new_sum_d = beat_new;
            cnt_d     = CNT_W'(1);
          end else begin
            cur_sum_d = cur_sum_q + beat_cur;
            new_sum_d = new_sum_q + beat_new;
            cnt_d     = cnt_q + CNT_W'(1);
          end
          if (in_last || (cnt_d == CNT_W'(MAX_NEIGH))) begin
            state_d = HOLD;
            trunc_d = ~in_last;
`ifdef SA_COST_THRESH_EN
            thresh_d = thresh;
`endif
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d   = ACC;
          cur_sum_d = '0;
          new_sum_d = '0;
          cnt_d     = '0;
          trunc_d   = 1'b0;
        end
      end
      default: state_d = ACC;
    endcase

    in_ready  = (state_q == ACC);
    out_valid = (state_q == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      cur_sum_q <= '0;
      new_sum_q <= '0;
      cnt_q     <= '0;
      trunc_q   <= 1'b0;
`ifdef SA_COST_THRESH_EN
      thresh_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cur_sum_q <= cur_sum_d;
      new_sum_q <= new_sum_d;
      cnt_q     <= cnt_d;
      trunc_q   <= trunc_d;
`ifdef SA_COST_THRESH_EN
      thresh_q  <= thresh_d;
`endif
    end
  end

  sa_delta_cmp u_cmp (
    .cur_sum (cur_sum_q),
    .new_sum (new_sum_q),
`ifdef SA_COST_THRESH_EN
    .thresh  (thresh_q),
`endif
    .delta   (out_delta),
    .accept  (cmp_accept)
  );

  assign out_accept  = (state_q == HOLD) && cmp_accept;
  assign out_cur_sum = cur_sum_q;
  assign out_new_sum = new_sum_q;
  assign out_beats   = cnt_q;
  assign out_trunc   = trunc_q;

endmodule

// File: tb/tb_sa_cost_accumulator.sv
// Self-checking bench for sa_cost_accumulator: vector table, corner
// sequences and randomized candidates against a sum-based reference model.
module tb_sa_cost_accumulator;
  import sa_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              in_valid, in_ready, in_first, in_last;
  logic [DIST_W-1:0] cur_da, cur_db, new_da, new_db;
  logic              out_valid, out_ready, out_accept;
  logic [SUM_W:0]    out_delta;
  logic [SUM_W-1:0]  out_cur_sum, out_new_sum;
  logic [CNT_W-1:0]  out_beats;
  logic              out_trunc;
  logic [7:0]        thresh;

  int checks = 0;
  int errors = 0;

  sa_cost_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_first    (in_first),
    .in_last     (in_last),
    .cur_da      (cur_da),
    .cur_db      (cur_db),
    .new_da      (new_da),
    .new_db      (new_db),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_accept  (out_accept),
    .out_delta   (out_delta),
    .out_cur_sum (out_cur_sum),
    .out_new_sum (out_new_sum),
    .out_beats   (out_beats),
    .out_trunc   (out_trunc)
`ifdef SA_COST_THRESH_EN
    ,
    .thresh      (thresh)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ca, cb, na, nb;
    int ecur, enew, edelta, eacc;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic beat(input logic f, input logic l,
                      input int ca, input int cb, input int na, input int nb);
    int g;
    in_first = f; in_last = l;
    cur_da = DIST_W'(ca); cur_db = DIST_W'(cb);
    new_da = DIST_W'(na); new_db = DIST_W'(nb);
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    if (!in_ready) chk("beat_ready_timeout", 0, 1);
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic expect_dec(input string tag, input int ecur, input int enew,
                            input int eacc, input int ebeats, input int etrunc);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_cur"},   int'(out_cur_sum), ecur);
    chk({tag, "_new"},   int'(out_new_sum), enew);
    chk({tag, "_delta"}, int'($signed(out_delta)), enew - ecur);
    chk({tag, "_acc"},   int'(out_accept), eacc);
    chk({tag, "_beats"}, int'(out_beats), ebeats);
    chk({tag, "_trunc"}, int'(out_trunc), etrunc);
  endtask

  task automatic release_dec();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", int'(out_valid), 0);
    chk("release_ready", int'(in_ready), 1);
  endtask

  function automatic int ref_accept(input int delta, input int th);
`ifdef SA_COST_THRESH_EN
    return (delta <= th) ? 1 : 0;
`else
    return (delta <= 0) ? 1 : 0;
`endif
  endfunction

  vec_t vecs[6];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    cur_da = '0; cur_db = '0; new_da = '0; new_db = '0;
    out_ready = 1'b0; thresh = 8'd0;

    vecs[0] = '{1, 1, 2, 1, 2, 3, 1, 0};
    vecs[1] = '{3, 3, 3, 3, 6, 6, 0, 1};
    vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 1};
    vecs[3] = '{1023, 1023, 0, 0, 2046, 0, -2046, 1};
    vecs[4] = '{0, 0, 1023, 1023, 0, 2046, 2046, 0};
    vecs[5] = '{10, 0, 0, 11, 10, 11, 1, 0};

    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_cur",   int'(out_cur_sum), 0);
    chk("rst_delta", int'($signed(out_delta)), 0);
    chk("rst_acc",   int'(out_accept), 0);
    chk("rst_beats", int'(out_beats), 0);
    chk("rst_trunc", int'(out_trunc), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Greedy improve, two beats
    beat(1'b1, 1'b0, 5, 3, 2, 1);
    chk("greedy_mid_valid", int'(out_valid), 0);
    beat(1'b0, 1'b1, 4, 4, 3, 3);
    expect_dec("greedy", 16, 9, 1, 2, 0);
    chk("greedy_delta_lit", int'($signed(out_delta)), -7);
    release_dec();

    // Single-beat vector table
    foreach (vecs[i]) begin
      beat(1'b1, 1'b1, vecs[i].ca, vecs[i].cb, vecs[i].na, vecs[i].nb);
      expect_dec($sformatf("vec%0d", i), vecs[i].ecur, vecs[i].enew,
                 vecs[i].eacc, 1, 0);
      chk($sformatf("vec%0d_dlit", i), int'($signed(out_delta)), vecs[i].edelta);
      release_dec();
    end

    // Backpressure: hold decision while the next beat waits
    beat(1'b1, 1'b1, 3, 3, 3, 3);
    in_first = 1'b1; in_last = 1'b1;
    cur_da = 10'd2; cur_db = 10'd2; new_da = 10'd1; new_db = 10'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_ready", int'(in_ready), 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_cur", int'(out_cur_sum), 6);
      chk("bp_acc", int'(out_accept), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_rel_valid", int'(out_valid), 0);
    chk("bp_rel_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    expect_dec("bp_next", 4, 2, 1, 1, 0);
    release_dec();

    // Truncation at MAX_NEIGH
    for (int i = 0; i < 3; i++) begin
      beat(i == 0, 1'b0, 1, 1, 1, 1);
      chk("trunc_mid_valid", int'(out_valid), 0);
    end
    beat(1'b0, 1'b0, 1, 1, 1, 1);
    expect_dec("trunc", 8, 8, 1, 4, 1);
    release_dec();

    // Restart via in_first on the second beat
    beat(1'b1, 1'b0, 5, 5, 0, 0);
    beat(1'b1, 1'b0, 1, 2, 3, 4);
    beat(1'b0, 1'b1, 1, 1, 1, 1);
    expect_dec("restart", 5, 9, 0, 2, 0);
    release_dec();

    // Max-value style beats from the plan
    for (int i = 0; i < 4; i++) beat(i == 0, 1'b0, 8, 8, 8, 8);
    expect_dec("eights", 64, 64, 1, 4, 1);
    release_dec();
    for (int i = 0; i < 4; i++) beat(i == 0, i == 3, 1023, 1023, 1023, 1000);
    expect_dec("maxval", 8184, 8092, 1, 4, 0);
    release_dec();

    // Reset in HOLD: asynchronous drop
    beat(1'b1, 1'b1, 7, 7, 9, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("rsthold_valid", int'(out_valid), 0);
    chk("rsthold_cur", int'(out_cur_sum), 0);
    chk("rsthold_new", int'(out_new_sum), 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    // Reset mid-accumulation
    beat(1'b1, 1'b0, 20, 20, 20, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("rstacc_cur", int'(out_cur_sum), 0);
    chk("rstacc_beats", int'(out_beats), 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1'b0, 1'b1, 2, 0, 1, 0);
    expect_dec("post_rst", 2, 1, 1, 1, 0);
    release_dec();

`ifdef SA_COST_THRESH_EN
    thresh = 8'd3;
    beat(1'b1, 1'b1, 0, 0, 2, 1);
    expect_dec("th_p3", 0, 3, 1, 1, 0);
    thresh = 8'd0;
    @(posedge clk); #1;
    chk("th_hold_acc", int'(out_accept), 1);
    release_dec();
    thresh = 8'd3;
    beat(1'b1, 1'b1, 0, 0, 2, 2);
    expect_dec("th_p4", 0, 4, 0, 1, 0);
    release_dec();
`endif

    // Randomized candidates against the reference model
    for (int c = 0; c < 60; c++) begin
      int n, sc, sn, a, b, d, e, th;
      logic last_end;
      n = $urandom_range(1, MAX_NEIGH);
      last_end = (n < MAX_NEIGH) ? 1'b1 : 1'($urandom_range(0, 1));
      th = $urandom_range(0, 255);
      thresh = 8'(th);
      sc = 0; sn = 0;
      for (int k = 0; k < n; k++) begin
        a = $urandom_range(0, 1023); b = $urandom_range(0, 1023);
        d = $urandom_range(0, 1023); e = $urandom_range(0, 1023);
        if ((c % 4) == 0 && k < n - 1) begin
          d = a; e = b;
        end
        sc += a + b; sn += d + e;
        beat((k == 0) ? 1'($urandom_range(0, 1)) : 1'b0,
             (k == n - 1) ? last_end : 1'b0, a, b, d, e);
      end
      expect_dec($sformatf("rnd%0d", c), sc, sn, ref_accept(sn - sc, th),
                 n, (n == MAX_NEIGH && !last_end) ? 1 : 0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk("rnd_hold_cur", int'(out_cur_sum), sc);
      end
      release_dec();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
